// File: rtl/sparse_acc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sparse_acc_ctrl_pkg
// Shared types and constants for the sparse accumulation controller:
// FSM state encoding, lane/product/tree-sum widths and saturation bounds.
// -----------------------------------------------------------------------------
package sparse_acc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int NLANE  = 4;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 20;

    // Bounds returned at 64 bits; callers cast down to their accumulator width.
    function automatic logic signed [63:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/sparse_acc_ctrl_if.sv
// -----------------------------------------------------------------------------
// sparse_acc_ctrl_if
// Bundles the job-control, product-group stream and result handshake signals
// of the sparse accumulation controller.
//   master : drives i_* (multiplier array / sequencer side), observes o_*
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface sparse_acc_ctrl_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic                    i_start;
    logic [LEN_W-1:0]        i_len;
    logic                    i_vld;
    logic                    o_rdy;
    logic signed [15:0]      i_val0;
    logic signed [15:0]      i_val1;
    logic signed [15:0]      i_val2;
    logic signed [15:0]      i_val3;
    logic [3:0]              i_mask;
    logic signed [ACC_W-1:0] o_acc;
    logic                    o_acc_vld;
    logic                    i_acc_rdy;
    logic                    o_busy;
    logic                    o_sat;
    logic [LEN_W-1:0]        o_skip_cnt;

    modport master (
        output i_start, i_len, i_vld, i_val0, i_val1, i_val2, i_val3,
               i_mask, i_acc_rdy,
        input  o_rdy, o_acc, o_acc_vld, o_busy, o_sat, o_skip_cnt
    );

    modport slave (
        input  i_start, i_len, i_vld, i_val0, i_val1, i_val2, i_val3,
               i_mask, i_acc_rdy,
        output o_rdy, o_acc, o_acc_vld, o_busy, o_sat, o_skip_cnt
    );

endinterface

// File: rtl/sparse_acc_ctrl_addertree.sv
// -----------------------------------------------------------------------------
// sparse_acc_ctrl_addertree
// Combinational 4-lane signed adder tree with per-lane select.
//   i_val0..i_val3 : signed PROD_W-bit lane products
//   sel            : lane enables, bit k gates i_valk
//   o_val          : signed SUM_W-bit sum of the selected lanes
// -----------------------------------------------------------------------------
module sparse_acc_ctrl_addertree
    import sparse_acc_ctrl_pkg::*;
(
    input  logic signed [PROD_W-1:0] i_val0,
    input  logic signed [PROD_W-1:0] i_val1,
    input  logic signed [PROD_W-1:0] i_val2,
    input  logic signed [PROD_W-1:0] i_val3,
    input  logic [NLANE-1:0]         sel,
    output logic signed [SUM_W-1:0]  o_val
);

    logic signed [SUM_W-1:0] lane0;
    logic signed [SUM_W-1:0] lane1;
    logic signed [SUM_W-1:0] lane2;
    logic signed [SUM_W-1:0] lane3;
    logic signed [SUM_W-1:0] pair01;
    logic signed [SUM_W-1:0] pair23;

    always_comb begin
        lane0 = sel[0] ? {{(SUM_W-PROD_W){i_val0[PROD_W-1]}}, i_val0} : '0;
        lane1 = sel[1] ? {{(SUM_W-PROD_W){i_val1[PROD_W-1]}}, i_val1} : '0;
        lane2 = sel[2] ? {{(SUM_W-PROD_W){i_val2[PROD_W-1]}}, i_val2} : '0;
        lane3 = sel[3] ? {{(SUM_W-PROD_W){i_val3[PROD_W-1]}}, i_val3} : '0;
        pair01 = lane0 + lane1;
        pair23 = lane2 + lane3;
        o_val  = pair01 + pair23;
    end

endmodule

// File: rtl/sparse_acc_ctrl.sv
// -----------------------------------------------------------------------------
// sparse_acc_ctrl
// Accumulates a programmed number of sparse product groups through one 4-lane
// adder tree into a saturating accumulator and hands the partial sum to the
// output buffer over a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sparse_acc_ctrl_if.slave (job start/length, group stream with
//              mask, result handshake, busy/sat/skip status)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for i_start; last result/status still visible
//   ACCUM | o_rdy=1, one group consumed per i_vld cycle
//   OUT   | result presented with o_acc_vld=1 until i_acc_rdy
// -----------------------------------------------------------------------------
module sparse_acc_ctrl #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    sparse_acc_ctrl_if.slave  bus
);
    import sparse_acc_ctrl_pkg::*;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        len_q,   len_d;
    logic [LEN_W-1:0]        cnt_q,   cnt_d;
    logic [LEN_W-1:0]        skip_q,  skip_d;
    logic signed [ACC_W-1:0] acc_q,   acc_d;
    logic                    sat_q,   sat_d;

    logic                    beat;
    logic [NLANE-1:0]        tree_sel;
    logic signed [SUM_W-1:0] tree_sum;
    logic signed [ACC_W:0]   sum_ext;
    logic                    ovf;
    logic signed [ACC_W-1:0] acc_next;

    sparse_acc_ctrl_addertree u_tree (
        .i_val0 (bus.i_val0),
        .i_val1 (bus.i_val1),
        .i_val2 (bus.i_val2),
        .i_val3 (bus.i_val3),
        .sel    (tree_sel),
        .o_val  (tree_sum)
    );

    // Tree lanes are only opened on an accepted beat so idle inputs do not
    // toggle the adders.
    always_comb begin
        beat     = (state_q == ACCUM) && bus.i_vld;
        tree_sel = beat ? bus.i_mask : '0;

        // One guard bit: the two top bits disagree exactly when the sum left
        // the ACC_W range.
        sum_ext  = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-SUM_W){tree_sum[SUM_W-1]}}, tree_sum};
        ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        if (ovf) begin
            acc_next = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum_ext[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        acc_d   = acc_q;
        sat_d   = sat_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    len_d   = bus.i_len;
                    cnt_d   = '0;
                    skip_d  = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = (bus.i_len == '0) ? OUT : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_next;
                    sat_d = sat_q | ovf;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (bus.i_mask == '0) begin
                        skip_d = skip_q + LEN_W'(1);
                    end
                    // Compare before incrementing so len = 2^LEN_W-1 never
                    // needs the counter to reach a wrapped value.
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.i_acc_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            skip_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign bus.o_rdy      = (state_q == ACCUM);
    assign bus.o_acc_vld  = (state_q == OUT);
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_acc      = acc_q;
    assign bus.o_sat      = sat_q;
    assign bus.o_skip_cnt = skip_q;

endmodule

// File: tb/tb_sparse_acc_ctrl.sv
module tb_sparse_acc_ctrl;

    localparam int ACC_W = 20;
    localparam int LEN_W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    sparse_acc_ctrl_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    sparse_acc_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        bus.i_start = 1'b1;
        bus.i_len   = LEN_W'(len);
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic grp(input int v0, input int v1, input int v2, input int v3,
                       input logic [3:0] m, input logic vld);
        bus.i_val0 = 16'(v0);
        bus.i_val1 = 16'(v1);
        bus.i_val2 = 16'(v2);
        bus.i_val3 = 16'(v3);
        bus.i_mask = m;
        bus.i_vld  = vld;
        tick();
        bus.i_vld  = 1'b0;
    endtask

    task automatic drain();
        bus.i_acc_rdy = 1'b1;
        tick();
        bus.i_acc_rdy = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rdy"},  longint'(bus.o_rdy),      0);
        check({pfx, "_vld"},  longint'(bus.o_acc_vld),  0);
        check({pfx, "_busy"}, longint'(bus.o_busy),     0);
        check({pfx, "_sat"},  longint'(bus.o_sat),      0);
        check({pfx, "_acc"},  longint'(bus.o_acc),      0);
        check({pfx, "_skip"}, longint'(bus.o_skip_cnt), 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_len     = '0;
        bus.i_vld     = 1'b0;
        bus.i_val0    = '0;
        bus.i_val1    = '0;
        bus.i_val2    = '0;
        bus.i_val3    = '0;
        bus.i_mask    = '0;
        bus.i_acc_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Basic: 15 = (1+2+3+4) + (10-5) + 0 (skipped)
        start(3);
        check("basic_rdy", longint'(bus.o_rdy), 1);
        grp(1, 2, 3, 4, 4'hF, 1'b1);
        grp(10, 0, 0, -5, 4'h9, 1'b1);
        check("basic_vld_early", longint'(bus.o_acc_vld), 0);
        check("basic_acc_mid",   longint'(bus.o_acc), 15);
        grp(7, 7, 7, 7, 4'h0, 1'b1);
        check("basic_vld",  longint'(bus.o_acc_vld), 1);
        check("basic_acc",  longint'(bus.o_acc), 15);
        check("basic_skip", longint'(bus.o_skip_cnt), 1);
        check("basic_sat",  longint'(bus.o_sat), 0);
        check("basic_rdy_out", longint'(bus.o_rdy), 0);
        drain();
        check("basic_idle_vld",  longint'(bus.o_acc_vld), 0);
        check("basic_idle_busy", longint'(bus.o_busy), 0);
        check("basic_idle_acc",  longint'(bus.o_acc), 15);
        check("basic_idle_skip", longint'(bus.o_skip_cnt), 1);

        // Mask gating: lanes 0 and 2 only
        start(1);
        grp(100, 200, 300, 400, 4'b0101, 1'b1);
        check("mask_vld", longint'(bus.o_acc_vld), 1);
        check("mask_acc", longint'(bus.o_acc), 400);
        check("mask_skip", longint'(bus.o_skip_cnt), 0);
        drain();

        // Backpressure and bubbles: beats carry 1,2,4,8; bubbles carry junk
        start(4);
        grp(1, 0, 0, 0, 4'h1, 1'b1);
        grp(1000, 1000, 1000, 1000, 4'hF, 1'b0);
        grp(2, 0, 0, 0, 4'h1, 1'b1);
        grp(1000, 1000, 1000, 1000, 4'hF, 1'b0);
        grp(4, 0, 0, 0, 4'h1, 1'b1);
        check("bp_still_accum", longint'(bus.o_rdy), 1);
        check("bp_acc_3beats",  longint'(bus.o_acc), 7);
        grp(8, 0, 0, 0, 4'h1, 1'b1);
        bus.i_vld  = 1'b1;
        bus.i_val0 = 16'(1000);
        bus.i_mask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_stall_vld%0d", i), longint'(bus.o_acc_vld), 1);
            check($sformatf("bp_stall_acc%0d", i), longint'(bus.o_acc), 15);
            tick();
        end
        bus.i_vld = 1'b0;
        drain();
        check("bp_idle_vld",  longint'(bus.o_acc_vld), 0);
        check("bp_idle_busy", longint'(bus.o_busy), 0);
        check("bp_idle_acc",  longint'(bus.o_acc), 15);

        // Positive saturation: 4 groups reach 524272, the 5th clamps
        start(20);
        check("satp_cleared", longint'(bus.o_sat), 0);
        for (int i = 0; i < 4; i++) grp(32767, 32767, 32767, 32767, 4'hF, 1'b1);
        check("satp_acc4", longint'(bus.o_acc), 524272);
        check("satp_sat4", longint'(bus.o_sat), 0);
        for (int i = 4; i < 20; i++) grp(32767, 32767, 32767, 32767, 4'hF, 1'b1);
        check("satp_vld", longint'(bus.o_acc_vld), 1);
        check("satp_acc", longint'(bus.o_acc), 524287);
        check("satp_sat", longint'(bus.o_sat), 1);
        drain();
        check("satp_sat_idle", longint'(bus.o_sat), 1);

        // Negative saturation: 4 groups land exactly on the minimum, no clamp
        start(20);
        check("satn_cleared", longint'(bus.o_sat), 0);
        for (int i = 0; i < 4; i++) grp(-32768, -32768, -32768, -32768, 4'hF, 1'b1);
        check("satn_acc4", longint'(bus.o_acc), -524288);
        check("satn_sat4", longint'(bus.o_sat), 0);
        for (int i = 4; i < 20; i++) grp(-32768, -32768, -32768, -32768, 4'hF, 1'b1);
        check("satn_acc", longint'(bus.o_acc), -524288);
        check("satn_sat", longint'(bus.o_sat), 1);
        drain();

        // len = 0, and a start coinciding with the OUT handshake
        start(0);
        check("len0_vld",  longint'(bus.o_acc_vld), 1);
        check("len0_acc",  longint'(bus.o_acc), 0);
        check("len0_skip", longint'(bus.o_skip_cnt), 0);
        check("len0_sat",  longint'(bus.o_sat), 0);
        bus.i_acc_rdy = 1'b1;
        bus.i_start   = 1'b1;
        bus.i_len     = LEN_W'(3);
        tick();
        bus.i_acc_rdy = 1'b0;
        bus.i_start   = 1'b0;
        check("start_in_out_ignored", longint'(bus.o_busy), 0);

        // i_start during ACCUM is ignored
        start(2);
        grp(3, 0, 0, 0, 4'h1, 1'b1);
        bus.i_start = 1'b1;
        bus.i_len   = '0;
        tick();
        bus.i_start = 1'b0;
        check("start_in_accum_rdy", longint'(bus.o_rdy), 1);
        grp(4, 0, 0, 0, 4'h1, 1'b1);
        check("start_in_accum_vld", longint'(bus.o_acc_vld), 1);
        check("start_in_accum_acc", longint'(bus.o_acc), 7);
        drain();

        // Maximum length: odd groups add 1, even groups are empty
        start(255);
        for (int i = 0; i < 254; i++) grp(1, 0, 0, 0, (i % 2 == 1) ? 4'h1 : 4'h0, 1'b1);
        check("len255_not_done", longint'(bus.o_rdy), 1);
        check("len255_vld_early", longint'(bus.o_acc_vld), 0);
        grp(1, 0, 0, 0, 4'h0, 1'b1);
        check("len255_vld",  longint'(bus.o_acc_vld), 1);
        check("len255_acc",  longint'(bus.o_acc), 127);
        check("len255_skip", longint'(bus.o_skip_cnt), 128);
        drain();

        // Reset mid-ACCUM, then a clean job
        start(5);
        grp(9, 9, 9, 9, 4'hF, 1'b1);
        grp(1, 1, 1, 1, 4'h0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        start(1);
        grp(5, 0, 0, 0, 4'h1, 1'b1);
        check("post_rst_vld", longint'(bus.o_acc_vld), 1);
        check("post_rst_acc", longint'(bus.o_acc), 5);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
